// File: rtl/anim_sequencer.sv
// Simon light/sound animation sequencer: WIN chase, LOSE flash and BOUNCE patterns over N lights.
// Optional tone output is enabled by defining ANIM_SOUND_EN; otherwise sound is tied to 0.
module anim_sequencer #(
  parameter int N_LIGHTS    = 4,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int REPEATS     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                next,
  input  logic [1:0]          mode,
  output logic [N_LIGHTS-1:0] lights,
  output logic [3:0]          sound,
  output logic                busy,
  output logic                done
);

  localparam int T_WIN  = N_LIGHTS * REPEATS;
  localparam int T_LOSE = 2 * REPEATS;
  localparam int T_BNC  = (2 * N_LIGHTS - 2) * REPEATS;
  localparam int T_MAX  = (T_BNC > T_WIN) ? ((T_BNC > T_LOSE) ? T_BNC : T_LOSE)
                                          : ((T_WIN > T_LOSE) ? T_WIN : T_LOSE);
  localparam int KW = $clog2(T_MAX + 1);
  localparam int CW = $clog2(STEP_CYCLES + 1);
  // At least two bits so the tone index can always be taken from pos[1:0].
  localparam int PW = $clog2(N_LIGHTS + 1);

  localparam logic [1:0] M_LOSE = 2'd1;
  localparam logic [1:0] M_BNC  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [KW-1:0]         k_q, k_d, k_last;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic                  dir_q, dir_d;
  logic [N_LIGHTS-1:0]   lights_q, lights_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  show_d;
  logic                  step_end;

  always_comb begin
    case (mode_q)
      M_LOSE:  k_last = KW'(T_LOSE - 1);
      M_BNC:   k_last = KW'(T_BNC - 1);
      default: k_last = KW'(T_WIN - 1);
    endcase
  end

  assign step_end = (cnt_q == CW'(STEP_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    show_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (next) begin
          state_d = S_PLAY;
          mode_d  = mode;
          k_d     = '0;
          cnt_d   = '0;
          pos_d   = '0;
          dir_d   = 1'b0;
          busy_d  = 1'b1;
          show_d  = 1'b1;
        end
      end
      S_PLAY: begin
        busy_d = 1'b1;
        show_d = 1'b1;
        if (step_end) begin
          cnt_d = '0;
          if (k_q == k_last) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            show_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
            // BOUNCE reverses at either end; other patterns wrap the position.
            if (mode_q == M_BNC) begin
              if (!dir_q) begin
                if (pos_q == PW'(N_LIGHTS - 1)) begin
                  dir_d = 1'b1;
                  pos_d = pos_q - 1'b1;
                end else begin
                  pos_d = pos_q + 1'b1;
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = 1'b0;
                  pos_d = pos_q + 1'b1;
                end else begin
                  pos_d = pos_q - 1'b1;
                end
              end
            end else begin
              pos_d = (pos_q == PW'(N_LIGHTS - 1)) ? '0 : pos_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    lights_d = '0;
    if (show_d) begin
      if (mode_d == M_LOSE) lights_d = k_d[0] ? '0 : '1;
      else                  lights_d = N_LIGHTS'(1) << pos_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      lights_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      lights_q <= lights_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign lights = lights_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef ANIM_SOUND_EN
  // WIN tone follows k mod 4, which differs from the light position when N_LIGHTS is not a multiple of 4.
  logic [1:0] ton_q, ton_d;
  logic [3:0] sound_q, sound_d;
  logic       ton_start, ton_adv;

  always_comb begin
    ton_start = (state_q == S_IDLE) && next;
    ton_adv   = (state_q == S_PLAY) && step_end && (k_q != k_last);
    ton_d     = ton_q;
    if (ton_start)    ton_d = 2'd0;
    else if (ton_adv) ton_d = (ton_q == 2'd3) ? 2'd0 : ton_q + 2'd1;
    sound_d = 4'b0000;
    if (show_d) begin
      case (mode_d)
        M_LOSE:  sound_d = k_d[0] ? 4'b0000 : 4'b1000;
        M_BNC:   sound_d = 4'b0001 << pos_d[1:0];
        default: sound_d = 4'b0001 << ton_d;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ton_q   <= 2'd0;
      sound_q <= 4'b0000;
    end else begin
      ton_q   <= ton_d;
      sound_q <= sound_d;
    end
  end

  assign sound = sound_q;
`else
  assign sound = 4'b0000;
`endif

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer (N_LIGHTS=4, STEP_CYCLES=4, REPEATS=2).
// Expected per-cycle outputs are queued when a run is started and popped each cycle.
module tb_anim_sequencer;
  localparam int N = 4;
  localparam int S = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       next;
  logic [1:0] mode;
  logic [3:0] lights;
  logic [3:0] sound;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  anim_sequencer #(.N_LIGHTS(N), .STEP_CYCLES(S), .REPEATS(R)) dut (
    .clk    (clk),
    .reset  (reset),
    .next   (next),
    .mode   (mode),
    .lights (lights),
    .sound  (sound),
    .busy   (busy),
    .done   (done)
  );

  function automatic int total_steps(input int m);
    if (m == 1)      return 2 * R;
    else if (m == 2) return (2 * N - 2) * R;
    else             return N * R;
  endfunction

  // {lights, sound, busy, done} for step k of pattern m
  function automatic logic [9:0] step_vec(input int m, input int k);
    logic [3:0] l;
    logic [3:0] s;
    int q;
    int pos;
    l = 4'b0000;
    s = 4'b0000;
    if (m == 1) begin
      if (k % 2 == 0) begin
        l = 4'b1111;
        s = 4'b1000;
      end
    end else if (m == 2) begin
      q   = k % (2 * N - 2);
      pos = (q < N) ? q : (2 * N - 2 - q);
      l   = 4'b0001 << pos;
      s   = 4'b0001 << (pos % 4);
    end else begin
      l = 4'b0001 << (k % N);
      s = 4'b0001 << (k % 4);
    end
`ifndef ANIM_SOUND_EN
    s = 4'b0000;
`endif
    return {l, s, 2'b10};
  endfunction

  function automatic void push_run(input int m);
    for (int c = 1; c <= total_steps(m) * S; c++) exp_q.push_back(step_vec(m, (c - 1) / S));
    exp_q.push_back(10'b0000_0000_01);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(10'b0);
  endfunction

  task automatic test_reset();
    logic [9:0] act;
    reset = 1'b1;
    next  = 1'b1;
    mode  = 2'd0;
    repeat (2) begin
      @(negedge clk);
      act = {lights, sound, busy, done};
      checks++;
      if (act !== 10'b0) begin
        failures++;
        $display("FAIL reset_state: got %b expected %b", act, 10'b0);
      end
    end
    next  = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pattern(input int m, input string tag);
    logic [9:0] act;
    logic [9:0] e;
    int n;
    mode = m[1:0];
    next = 1'b1;
    push_run(m);
    push_idle(2);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      next = 1'b0;
      act  = {lights, sound, busy, done};
      e    = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s cycle %0d: got %b expected %b", tag, c, act, e);
      end
    end
  endtask

  task automatic test_ignore_next();
    logic [9:0] act;
    logic [9:0] e;
    int n;
    mode = 2'd0;
    next = 1'b1;
    push_run(0);
    push_idle(2);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      act = {lights, sound, busy, done};
      e   = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL ignore_next cycle %0d: got %b expected %b", c, act, e);
      end
      if (c == 10) begin
        next = 1'b1;
        mode = 2'd1;
      end else begin
        next = 1'b0;
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] act;
    logic [9:0] e;
    mode = 2'd0;
    next = 1'b1;
    for (int c = 1; c <= 7; c++) exp_q.push_back(step_vec(0, (c - 1) / S));
    push_idle(30);
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      next = 1'b0;
      act  = {lights, sound, busy, done};
      e    = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", c, act, e);
      end
      reset = (c == 7);
    end
  endtask

  task automatic test_reset_and_next();
    logic [9:0] act;
    reset = 1'b1;
    next  = 1'b1;
    mode  = 2'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      reset = 1'b0;
      next  = 1'b0;
      act   = {lights, sound, busy, done};
      checks++;
      if (act !== 10'b0) begin
        failures++;
        $display("FAIL reset_and_next cycle %0d: got %b expected %b", c, act, 10'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] act;
    logic [9:0] e;
    int n;
    mode = 2'd0;
    next = 1'b1;
    push_run(0);
    push_idle(1);
    push_run(1);
    push_idle(2);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      act = {lights, sound, busy, done};
      e   = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, act, e);
      end
      if (c == 33) begin
        next = 1'b1;
        mode = 2'd2;
      end else if (c == 34) begin
        next = 1'b1;
        mode = 2'd1;
      end else begin
        next = 1'b0;
      end
    end
    mode = 2'd0;
  endtask

  initial begin
    reset = 1'b0;
    next  = 1'b0;
    mode  = 2'd0;
    @(negedge clk);
    test_reset();
    test_pattern(0, "win");
    test_pattern(1, "lose");
    test_pattern(2, "bounce");
    test_pattern(3, "reserved_as_win");
    test_ignore_next();
    test_reset_mid();
    test_reset_and_next();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Parametrised light/sound animation sequencer for the Simon game. It generalises the fixed four-light round-win animation to N lights and adds selectable patterns (win chase, lose flash, bounce), a configurable step length and repeat count, and a busy/done handshake. The game controller pulses `next` with a `mode` after a round resolves, and waits for `done` before resuming play. Outputs drive the light drivers and the tone generator directly.

## Interface
- `N_LIGHTS`, 4: number of lights; legal range 2..16.
- `STEP_CYCLES`, 25_000_000: clock cycles each animation step is held; at least 1.
- `REPEATS`, 3: number of pattern passes; at least 1.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `next`  in  1  start pulse, sampled only in IDLE.
- `mode`  in  2  pattern select, latched on the accepted `next`: 0 WIN, 1 LOSE, 2 BOUNCE, 3 reserved (plays as WIN).
- `lights`  out  N_LIGHTS  light enables; bit i drives light i.
- `sound`  out  4  one-hot tone select; 0 means silent.
- `busy`  out  1  high while an animation is playing.
- `done`  out  1  one-cycle pulse when an animation finishes.

Clocking and reset:
- One clock; reset is synchronous and active-high.
- All outputs are registered.

## Operation
- States: IDLE, PLAY, DONE.
- IDLE:
  - All outputs are 0.
  - `next`=1 latches `mode`, clears the step index k and the hold counter, and enters PLAY.
- PLAY:
  - Outputs show step k; the hold counter counts 0..STEP_CYCLES-1.
  - At STEP_CYCLES-1 the counter returns to 0 and k increments.
  - After the last step, `lights` and `sound` go to 0 and the state moves to DONE.
- DONE:
  - Lasts one cycle: `done`=1, `busy`=0.
  - Then IDLE.
- Patterns, with T = total steps and p = k mod N_LIGHTS:
  - WIN: T = N_LIGHTS*REPEATS; `lights` = one-hot(p); `sound` = one-hot(k mod 4).
  - LOSE: T = 2*REPEATS; even k gives all lights on with `sound`=4'b1000; odd k gives `lights`=0 and `sound`=0.
  - BOUNCE: pass length P = 2*N_LIGHTS-2; T = P*REPEATS; q = k mod P; position = q when q<N_LIGHTS, otherwise P-q. `lights` = one-hot(position); `sound` = one-hot(position mod 4).
- `next` in PLAY or DONE is ignored; there is no queueing.
- A change on `mode` after latch has no effect until the next start.
- Counter widths:
  - Hold counter: $clog2(STEP_CYCLES+1) bits.
  - Step index: wide enough for the largest T over all modes.
  - Wrap uses explicit compare-and-clear. No reliance on power-of-two overflow.

## Timing
- Reset value: `lights`=0, `sound`=0, `busy`=0, `done`=0, state IDLE.
- Reset takes priority over everything. Reset mid-animation forces IDLE on the next edge, with no `done` pulse.
- `next` and `reset` high on the same edge: reset wins and `next` is dropped.
- Latency from start:
  - `next` sampled at edge E0.
  - From E0+1: `busy`=1 and step 0 is visible.
  - Step k occupies cycles E0+1+k*STEP_CYCLES .. E0+(k+1)*STEP_CYCLES.
- Completion: `done`=1 and `busy`=0 in cycle E0+1+T*STEP_CYCLES; IDLE from the following cycle.
- Back-to-back: `next` high during the DONE cycle is ignored. `next` in the first IDLE cycle after DONE is accepted.
- STEP_CYCLES=1: each step lasts exactly one cycle; no dead cycles between steps.

## Configuration
- `ANIM_SOUND_EN` defined: `sound` is driven as described under Operation.
- Not defined:
  - `sound` is constant 0.
  - No tone logic is synthesised.
  - Light behaviour and timing are identical to the defined case.

## Test plan
All scenarios use N_LIGHTS=4, STEP_CYCLES=4, REPEATS=2, with `ANIM_SOUND_EN` defined unless stated.
- WIN: reset, then `next`=1 for one cycle with `mode`=0.
  - `lights` steps 0001, 0010, 0100, 1000 twice, 4 cycles each (32 cycles).
  - `sound` follows the same one-hot pattern.
  - `done` is high for one cycle at cycle 33 after the sampling edge; `busy` is high for cycles 1..32.
- LOSE, `mode`=1: `lights` sequence 1111, 0000, 1111, 0000 with `sound` 1000, 0, 1000, 0; `done` at cycle 17.
- BOUNCE, `mode`=2: `lights` sequence 0001, 0010, 0100, 1000, 0100, 0010, repeated twice (48 cycles); `done` at cycle 49.
- Ignore and reset:
  - `next` pulsed again at cycle 10 of a WIN run: no effect, `done` still at cycle 33.
  - Separate run: `reset`=1 at cycle 7 gives all outputs 0 at cycle 8 and no `done` pulse.
  - `next` and `reset` on the same edge: stays in IDLE.
- Back-to-back and macro off:
  - `next` in the DONE cycle is ignored.
  - `next` one cycle later starts a new run.
  - Rebuilt without `ANIM_SOUND_EN`: the WIN run gives identical `lights` and `sound`=0 throughout.
